// File: rtl/rect_loop_loader_if.sv
// Stream-in / frame-out bundle for rect_loop_loader.
// The loader takes the slave view; whoever feeds bits and takes frames takes the master view.
interface rect_loop_loader_if #(
  parameter int MATRIX_ROW = 2,
  parameter int MATRIX_COL = 2,
  parameter int PARAM_W    = 12
);
  logic                             in_bit;
  logic                             in_valid;
  logic                             in_last;
  logic                             in_ready;
  logic [PARAM_W-1:0]               out_param;
  logic [MATRIX_ROW*MATRIX_COL-1:0] out_m;
  logic                             out_valid;
  logic                             out_ready;
  logic                             frame_err;
  logic [15:0]                      frame_cnt;

  modport master (
    output in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_param, out_m, out_valid, frame_err, frame_cnt
  );

  modport slave (
    input  in_bit, in_valid, in_last, out_ready,
    output in_ready, out_param, out_m, out_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/rect_loop_loader.sv
// Bit-serial frame assembler feeding rectangle_loop_2: param MSB first, then the matrix row-major.
// Optional trailing even-parity bit when RECT_LOOP_LOADER_PARITY_EN is defined.
module rect_loop_loader #(
  parameter int MATRIX_ROW = 2,
  parameter int MATRIX_COL = 2,
  parameter int PARAM_W    = 12
) (
  input  logic               clk,
  input  logic               reset,
  rect_loop_loader_if.slave  bus
);
  localparam int M_W    = MATRIX_ROW * MATRIX_COL;
  localparam int DATA_W = PARAM_W + M_W;
`ifdef RECT_LOOP_LOADER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int              CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HELD    = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // First matrix bit on the wire is m[0][0], which must land at out_m[0].
  function automatic logic [M_W-1:0] reverse_m(input logic [M_W-1:0] v);
    logic [M_W-1:0] r;
    r = '0;
    for (int i = 0; i < M_W; i++) begin
      r[i] = v[M_W-1-i];
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [PARAM_W-1:0] param_q, param_d;
  logic [M_W-1:0]     m_q, m_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [15:0]        fcnt_q, fcnt_d;

  logic              accept_s;
  logic              consume_s;
  logic              shift_en_s;
  logic              parity_ok_s;
  logic [DATA_W-1:0] shift_in_s;
  logic [DATA_W-1:0] frame_data_s;

  assign accept_s   = bus.in_valid && ready_q;
  assign consume_s  = valid_q && bus.out_ready;
  assign shift_in_s = {shift_q[DATA_W-2:0], bus.in_bit};

`ifdef RECT_LOOP_LOADER_PARITY_EN
  // The parity beat is checked against the buffer, never shifted into it.
  assign shift_en_s   = (cnt_q != LAST_IDX);
  assign frame_data_s = shift_q;
  assign parity_ok_s  = (bus.in_bit == even_parity(shift_q));
`else
  assign shift_en_s   = 1'b1;
  assign frame_data_s = shift_in_s;
  assign parity_ok_s  = 1'b1;
`endif

  // Next-state logic: assembly counter, framing checks, holding-register hand-off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    param_d = param_q;
    m_d     = m_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;

    if (consume_s) begin
      valid_d = 1'b0;
      fcnt_d  = fcnt_q + 16'd1;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          if (shift_en_s) begin
            shift_d = shift_in_s;
          end else begin
            shift_d = shift_q;
          end
          if (cnt_q != LAST_IDX) begin
            if (bus.in_last) begin
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
            if (!bus.in_last) begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end else if (!parity_ok_s) begin
              err_d = 1'b1;
            end else if (!valid_q || consume_s) begin
              param_d = frame_data_s[DATA_W-1:M_W];
              m_d     = reverse_m(frame_data_s[M_W-1:0]);
              valid_d = 1'b1;
            end else begin
              state_d = ST_HELD;
            end
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HELD: begin
        // valid_q is always set here, so out_ready alone means the slot frees up.
        if (bus.out_ready) begin
          param_d = shift_q[DATA_W-1:M_W];
          m_d     = reverse_m(shift_q[M_W-1:0]);
          valid_d = 1'b1;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_DROP: begin
        if (accept_s && bus.in_last) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d != ST_HELD);
  end

  // State and output registers; reset drops partial and held frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
      param_q <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      param_q <= param_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_param = param_q;
  assign bus.out_m     = m_q;
  assign bus.out_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = fcnt_q;
endmodule
